// File: rtl/inst_sequencer_if.sv
// Load port and processor control-FIFO port of the instruction sequencer.
// The slave modport is the sequencer's view; master is the driving environment.
interface inst_sequencer_if #(
  parameter int INST_WIDTH = 8
);
  logic                  load_valid;
  logic [INST_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  ctrl_fifo_enq;
  logic [INST_WIDTH-1:0] ctrl_fifo_data_in;
  logic                  ctrl_fifo_full;

  modport master (
    output load_valid, load_data, ctrl_fifo_full,
    input  load_ready, ctrl_fifo_enq, ctrl_fifo_data_in
  );

  modport slave (
    input  load_valid, load_data, ctrl_fifo_full,
    output load_ready, ctrl_fifo_enq, ctrl_fifo_data_in
  );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction sequencer: stores up to 2**PROG_ADDR_WIDTH instructions and streams
// them (repeat_count+1 passes) into a processor control FIFO, honouring full.
module inst_sequencer #(
  parameter int INST_WIDTH      = 8,
  parameter int PROG_ADDR_WIDTH = 4,
  parameter int REPEAT_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  inst_sequencer_if.slave          bus,
  input  logic                     clear,
  input  logic                     start,
  input  logic [REPEAT_WIDTH-1:0]  repeat_count,
  output logic [PROG_ADDR_WIDTH:0] prog_len,
  output logic                     busy,
  output logic                     done
);
  localparam int DEPTH = 2 ** PROG_ADDR_WIDTH;
  localparam logic [PROG_ADDR_WIDTH:0]   LEN_FULL = (PROG_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PROG_ADDR_WIDTH:0]   LEN_ONE  = (PROG_ADDR_WIDTH + 1)'(1);
  localparam logic [PROG_ADDR_WIDTH-1:0] PTR_ONE  = PROG_ADDR_WIDTH'(1);
  localparam logic [REPEAT_WIDTH-1:0]    CNT_ONE  = REPEAT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [PROG_ADDR_WIDTH:0]   len_nxt;
  logic [PROG_ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [REPEAT_WIDTH-1:0]    pass_cnt, pass_cnt_nxt;
  logic                       ready, load_accept, enq, last;
  logic [INST_WIDTH-1:0]      mem [DEPTH];

  // Clear wins over a simultaneous load; the store only fills while idle.
  assign ready       = (state == IDLE) && (prog_len < LEN_FULL);
  assign load_accept = ready && bus.load_valid && !clear;
  assign last        = ({1'b0, rd_ptr} == prog_len - LEN_ONE);
  assign bus.load_ready = ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      prog_len <= '0;
      rd_ptr   <= '0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prog_len <= len_nxt;
      rd_ptr   <= rd_ptr_nxt;
      pass_cnt <= pass_cnt_nxt;
    end
  end

  // Program store holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_accept) mem[prog_len[PROG_ADDR_WIDTH-1:0]] <= bus.load_data;
  end

  always_comb begin
    state_nxt             = state;
    len_nxt               = prog_len;
    rd_ptr_nxt            = rd_ptr;
    pass_cnt_nxt          = pass_cnt;
    enq                   = 1'b0;
    busy                  = 1'b0;
    done                  = 1'b0;
    bus.ctrl_fifo_data_in = '0;
    case (state)
      IDLE: begin
        if (clear) begin
          len_nxt = '0;
        end else begin
          if (load_accept) len_nxt = prog_len + LEN_ONE;
          // A load in the start cycle counts toward the program being run.
          if (start) begin
            if (len_nxt != '0) begin
              state_nxt    = RUN;
              rd_ptr_nxt   = '0;
              pass_cnt_nxt = repeat_count;
            end else begin
              state_nxt = DONE;
            end
          end
        end
      end
      RUN: begin
        busy                  = 1'b1;
        enq                   = !bus.ctrl_fifo_full;
        bus.ctrl_fifo_data_in = mem[rd_ptr];
        if (enq) begin
          if (last) begin
            rd_ptr_nxt = '0;
            if (pass_cnt == '0) state_nxt = DONE;
            else                pass_cnt_nxt = pass_cnt - CNT_ONE;
          end else begin
            rd_ptr_nxt = rd_ptr + PTR_ONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ctrl_fifo_enq = enq;
endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed scenarios plus randomized
// programs, checked against a queue-based model of the expected enqueue stream.
module tb_inst_sequencer;
  localparam int IW    = 8;
  localparam int PAW   = 4;
  localparam int RW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          start;
  logic [RW-1:0] repeat_count;
  logic [PAW:0]  prog_len;
  logic          busy;
  logic          done;

  inst_sequencer_if #(.INST_WIDTH(IW)) sif();

  inst_sequencer #(
    .INST_WIDTH(IW), .PROG_ADDR_WIDTH(PAW), .REPEAT_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset), .bus(sif), .clear(clear), .start(start),
    .repeat_count(repeat_count), .prog_len(prog_len), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [IW-1:0] prog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    sif.load_valid     = 1'b0;
    sif.load_data      = '0;
    sif.ctrl_fifo_full = 1'b0;
    clear              = 1'b0;
    start              = 1'b0;
    repeat_count       = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},       32'(busy), 32'(0));
    chk({tag, ".done"},       32'(done), 32'(0));
    chk({tag, ".enq"},        32'(sif.ctrl_fifo_enq), 32'(0));
    chk({tag, ".data"},       32'(sif.ctrl_fifo_data_in), 32'(0));
    chk({tag, ".prog_len"},   32'(prog_len), 32'(prog.size()));
    chk({tag, ".load_ready"}, 32'(sif.load_ready), 32'(prog.size() < DEPTH));
  endtask

  task automatic load_word(input logic [IW-1:0] v);
    bit exp_ready;
    exp_ready      = prog.size() < DEPTH;
    sif.load_valid = 1'b1;
    sif.load_data  = v;
    settle();
    chk("load.ready", 32'(sif.load_ready), 32'(exp_ready));
    if (exp_ready) prog.push_back(v);
    tick();
  endtask

  task automatic end_load(input string tag);
    sif.load_valid = 1'b0;
    settle();
    chk({tag, ".prog_len"}, 32'(prog_len), 32'(prog.size()));
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) load_word(IW'($urandom));
    end_load("load_rnd");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    settle();
    tick();
    clear = 1'b0;
    prog.delete();
  endtask

  // Expected stream is the program repeated rc+1 times; each non-full RUN
  // cycle must present the next item and enqueue it, full cycles hold it.
  task automatic run_prog(input int rc, input int full_pct, input int stall_after,
                          input int stall_len, input bit with_load, input string tag);
    logic [IW-1:0] expq[$];
    logic [IW-1:0] v;
    int   stall_left;
    int   enqs;
    int   cycles;
    bit   f;
    bit   forced;
    stall_left   = stall_len;
    enqs         = 0;
    cycles       = 0;
    start        = 1'b1;
    repeat_count = RW'(rc);
    if (with_load) begin
      v              = IW'($urandom);
      sif.load_valid = 1'b1;
      sif.load_data  = v;
      if (prog.size() < DEPTH) prog.push_back(v);
    end
    settle();
    chk({tag, ".start_enq"}, 32'(sif.ctrl_fifo_enq), 32'(0));
    for (int r = 0; r <= rc; r++)
      foreach (prog[i]) expq.push_back(prog[i]);
    tick();
    while (expq.size() > 0 && cycles < 1000) begin
      forced = (enqs >= stall_after) && (stall_left > 0);
      f      = forced ? 1'b1 : ($urandom_range(99) < full_pct);
      if (forced) stall_left--;
      sif.ctrl_fifo_full = f;
      sif.load_valid     = 1'($urandom);
      sif.load_data      = IW'($urandom);
      clear              = ($urandom_range(7) == 0);
      start              = ($urandom_range(7) == 0);
      repeat_count       = RW'($urandom);
      settle();
      chk({tag, ".busy"},       32'(busy), 32'(1));
      chk({tag, ".load_ready"}, 32'(sif.load_ready), 32'(0));
      chk({tag, ".prog_len"},   32'(prog_len), 32'(prog.size()));
      chk({tag, ".enq"},        32'(sif.ctrl_fifo_enq), 32'(!f));
      chk({tag, ".data"},       32'(sif.ctrl_fifo_data_in), 32'(expq[0]));
      if (!f) begin
        void'(expq.pop_front());
        enqs++;
      end
      tick();
      cycles++;
    end
    chk({tag, ".remaining"}, 32'(expq.size()), 32'(0));
    idle_inputs();
    settle();
    chk({tag, ".done"},       32'(done), 32'(1));
    chk({tag, ".done_busy"},  32'(busy), 32'(0));
    chk({tag, ".done_enq"},   32'(sif.ctrl_fifo_enq), 32'(0));
    chk({tag, ".done_data"},  32'(sif.ctrl_fifo_data_in), 32'(0));
    chk({tag, ".done_ready"}, 32'(sif.load_ready), 32'(0));
    tick();
    settle();
    check_idle({tag, ".after"});
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    settle();
    check_idle("reset");
    tick();
    reset = 1'b1;
    settle();

    // Basic three-instruction program, single and triple pass.
    load_word(8'h11); load_word(8'h22); load_word(8'h33);
    end_load("p3");
    run_prog(0, 0, 99, 0, 1'b0, "single");
    run_prog(2, 0, 99, 0, 1'b0, "triple");

    // Back-pressure right after the first enqueue.
    do_clear();
    load_word(8'hA0); load_word(8'hB1);
    end_load("p2");
    run_prog(0, 0, 1, 4, 1'b0, "stall");

    // Overfill, then clear and start on an empty store.
    do_clear();
    load_random(17);
    chk("full.prog_len", 32'(prog_len), 32'(DEPTH));
    chk("full.ready",    32'(sif.load_ready), 32'(0));
    do_clear();
    settle();
    chk("cleared.prog_len", 32'(prog_len), 32'(0));
    run_prog(3, 0, 99, 0, 1'b0, "empty");

    // Clear and start together: clear wins, nothing runs.
    load_random(5);
    clear = 1'b1;
    start = 1'b1;
    settle();
    tick();
    clear = 1'b0;
    start = 1'b0;
    prog.delete();
    settle();
    check_idle("clr_start");
    tick();
    settle();
    check_idle("clr_start2");

    // Load in the start cycle extends the program being run.
    load_random(3);
    run_prog(1, 20, 99, 0, 1'b1, "ld_start");

    // Randomized programs, replayed without reload on odd iterations.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        do_clear();
        load_random($urandom_range(1, 16));
      end
      run_prog($urandom_range(0, 3), 30, 99, 0, 1'($urandom_range(1)), "rnd");
    end

    // Asynchronous reset in the middle of the second pass.
    do_clear();
    load_random(3);
    start        = 1'b1;
    repeat_count = RW'(3);
    settle();
    tick();
    start = 1'b0;
    repeat (4) tick();
    settle();
    chk("midrun.enq", 32'(sif.ctrl_fifo_enq), 32'(1));
    #2;
    reset = 1'b0;
    prog.delete();
    #1;
    chk("arst.enq",        32'(sif.ctrl_fifo_enq), 32'(0));
    chk("arst.busy",       32'(busy), 32'(0));
    chk("arst.prog_len",   32'(prog_len), 32'(0));
    chk("arst.data",       32'(sif.ctrl_fifo_data_in), 32'(0));
    chk("arst.load_ready", 32'(sif.load_ready), 32'(1));
    chk("arst.done",       32'(done), 32'(0));
    tick();
    reset = 1'b1;
    settle();
    check_idle("post_rst");
    run_prog(2, 0, 99, 0, 1'b0, "post_rst_run");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameters SHALL be: INST_WIDTH, default 8, instruction width; PROG_ADDR_WIDTH, default 4, program store address width (depth 2**PROG_ADDR_WIDTH = 16); REPEAT_WIDTH, default 4, repeat-count width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 load_valid  input  1  load port strobe; load_data is written when load_valid && load_ready.
REQ-005 load_data  input  INST_WIDTH  instruction to append to the program store.
REQ-006 load_ready  output  1  program store accepts a write this cycle.
REQ-007 clear  input  1  empties the program store (prog_len <= 0).
REQ-008 start  input  1  begins streaming the stored program.
REQ-009 repeat_count  input  REPEAT_WIDTH  extra passes, sampled with start; total passes = repeat_count+1.
REQ-010 prog_len  output  PROG_ADDR_WIDTH+1  number of stored instructions.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  one-cycle pulse at end of streaming.
REQ-013 ctrl_fifo_enq  output  1  enqueue strobe to the processor control FIFO.
REQ-014 ctrl_fifo_data_in  output  INST_WIDTH  instruction presented to the control FIFO.
REQ-015 ctrl_fifo_full  input  1  control FIFO full back-pressure.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE: load_ready = (prog_len < 16); accepted write stores load_data at mem[prog_len], prog_len increments next edge.
REQ-018 IDLE with prog_len == 16: load_ready = 0, load_valid ignored, store unchanged.
REQ-019 clear in IDLE SHALL set prog_len to 0 next edge; clear has priority over load and start in the same cycle; memory contents need not be erased.
REQ-020 start in IDLE (no clear) with prog_len > 0: next edge enter RUN, rd_ptr <= 0, pass counter <= repeat_count.
REQ-021 start in IDLE with prog_len == 0: next edge enter DONE; no enqueue occurs.
REQ-022 start and accepted load in same IDLE cycle: load takes effect; RUN uses the incremented prog_len.
REQ-023 RUN: ctrl_fifo_enq = !ctrl_fifo_full (combinational); ctrl_fifo_data_in = mem[rd_ptr]; rd_ptr and pass counter advance only on cycles with ctrl_fifo_enq = 1.
REQ-024 RUN, enqueue at rd_ptr == prog_len-1: rd_ptr wraps to 0; if pass counter == 0 enter DONE, else pass counter decrements.
REQ-025 RUN with ctrl_fifo_full = 1: hold rd_ptr, pass counter, state; no enqueue; stall unbounded.
REQ-026 RUN: load_ready = 0; load_valid, clear, start ignored.
REQ-027 DONE: done = 1 for exactly one cycle, then IDLE; ctrl_fifo_enq = 0; load_ready = 0.
REQ-028 Total enqueues per start SHALL equal prog_len*(repeat_count+1), in program order per pass, no gaps while not full; first enqueue the cycle after start is sampled.
REQ-029 ctrl_fifo_data_in SHALL be 0 outside RUN.
REQ-030 Program store SHALL persist across runs; a second start replays it without reload.

Reset
REQ-031 Asserting reset (low) at any time, including mid-RUN, SHALL immediately force: state IDLE, prog_len 0, rd_ptr 0, pass counter 0, busy 0, done 0, ctrl_fifo_enq 0, ctrl_fifo_data_in 0, load_ready 1.
REQ-032 No partial run SHALL resume after reset deasserts; memory contents are don't-care.

Verification
REQ-033 Load 0x11,0x22,0x33; start, repeat_count=0, full=0 -> enq on 3 consecutive cycles with 0x11,0x22,0x33, then done pulse, busy low.
REQ-034 Same program, repeat_count=2 -> 9 enqueues 0x11,0x22,0x33 x3, prog_len stays 3.
REQ-035 Program 0xA0,0xB1; full high 4 cycles after first enq -> sequence 0xA0 (stall 4 cycles, no enq) 0xB1; no duplicate or lost instruction.
REQ-036 Load 17 instructions -> first 16 accepted, load_ready 0 at prog_len=16; clear -> prog_len 0; start -> done next cycle, zero enqueues.
REQ-037 Reset low during RUN mid pass 2 -> enq 0 immediately, prog_len 0; after release, start -> DONE with no enqueue.
REQ-038 Same cycle clear and start with prog_len=5 -> prog_len 0, state stays IDLE, no enqueue.
